rv32i_multicycle_ctrl: RTL

- Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over one shared instruction/data memory port.
- The instruction decoder still produces the ALU function code. This block produces only the per-cycle enables and mux selects for PC, IR, register file, ALU operands and memory.
- It sits between the datapath (PC, IR, regfile, ALU) and the memory handshake.

---
 rtl/rv32i_ctrl_pkg.sv | 34 +++
 rtl/rv32i_multicycle_ctrl_if.sv | 24 ++
 rtl/rv32i_multicycle_ctrl_timeout.sv | 29 ++
 rtl/rv32i_multicycle_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle controller: FSM states, opcode classes,
// ALU operand-B select encoding and trap causes.
package rv32i_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_ALU,
        ST_ADDR_CALC,
        ST_MEM_LOAD,
        ST_MEM_STORE,
        ST_WB_ALU,
        ST_WB_LOAD,
        ST_TRAP
    } ctrl_state_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } alu_src_b_e;

    typedef enum logic [1:0] {
        CAUSE_NONE        = 2'd0,
        CAUSE_ILLEGAL     = 2'd1,
        CAUSE_MEM_TIMEOUT = 2'd2
    } trap_cause_e;

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the controller (master)
// and the memory (slave).
interface rv32i_multicycle_ctrl_if;

    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );

endinterface

// File: rtl/rv32i_multicycle_ctrl_timeout.sv
// Memory wait watchdog: counts cycles an access stays outstanding and flags
// expiry when the limit is reached with the memory still not ready.
module mem_timeout_ctr #(
    parameter int MEM_TIMEOUT = 255,
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

    logic [TO_W-1:0] count;

    // The count saturates at LIMIT so a held expiry never wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst || !active || done) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = active && !done && (count == LIMIT);

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM over a single shared memory port.
// Optional performance counters are enabled with RV32I_CTRL_PERF_EN.
module rv32i_multicycle_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               opcode,
    rv32i_multicycle_ctrl_if.master  mem,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic                     reg_write,
    output logic                     wb_sel,
    output logic                     instr_retired,
    output logic                     trap,
    output logic [1:0]               trap_cause
`ifdef RV32I_CTRL_PERF_EN
    ,
    output logic [31:0]              cycle_count,
    output logic [31:0]              retired_count
`endif
);

    ctrl_state_e state, next_state;
    trap_cause_e cause_q, next_cause;
    alu_src_b_e  srcb_c;
    logic        req_c;
    logic        expired;

    mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .active  (req_c),
        .done    (mem.mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= next_state;
            cause_q <= next_cause;
        end
    end

    // Outputs are forced low while rst is high because the reset is synchronous
    // and the state register still holds the pre-reset state during that cycle.
    always_comb begin
        next_state       = state;
        next_cause       = cause_q;
        req_c            = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        alu_src_a        = 1'b0;
        srcb_c           = SRCB_RS2;
        reg_write        = 1'b0;
        wb_sel           = 1'b0;
        instr_retired    = 1'b0;
        trap             = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    req_c     = 1'b1;
                    alu_src_a = 1'b1;
                    srcb_c    = SRCB_FOUR;
                    if (mem.mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = ST_DECODE;
                    end else if (expired) begin
                        next_state = ST_TRAP;
                        next_cause = CAUSE_MEM_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_RTYPE, OP_ITYPE: next_state = ST_EXEC_ALU;
                        OP_LOAD, OP_STORE:  next_state = ST_ADDR_CALC;
                        default: begin
                            next_state = ST_TRAP;
                            next_cause = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                ST_EXEC_ALU: begin
                    srcb_c     = (opcode == OP_RTYPE) ? SRCB_RS2 : SRCB_IMM;
                    next_state = ST_WB_ALU;
                end
                ST_ADDR_CALC: begin
                    srcb_c     = SRCB_IMM;
                    next_state = (opcode == OP_LOAD) ? ST_MEM_LOAD : ST_MEM_STORE;
                end
                ST_MEM_LOAD: begin
                    req_c            = 1'b1;
                    mem.mem_addr_sel = 1'b1;
                    if (mem.mem_ready) begin
                        next_state = ST_WB_LOAD;
                    end else if (expired) begin
                        next_state = ST_TRAP;
                        next_cause = CAUSE_MEM_TIMEOUT;
                    end
                end
                ST_MEM_STORE: begin
                    req_c            = 1'b1;
                    mem.mem_we       = 1'b1;
                    mem.mem_addr_sel = 1'b1;
                    if (mem.mem_ready) begin
                        instr_retired = 1'b1;
                        next_state    = ST_FETCH;
                    end else if (expired) begin
                        next_state = ST_TRAP;
                        next_cause = CAUSE_MEM_TIMEOUT;
                    end
                end
                ST_WB_ALU, ST_WB_LOAD: begin
                    reg_write     = 1'b1;
                    wb_sel        = (state == ST_WB_LOAD);
                    instr_retired = 1'b1;
                    next_state    = ST_FETCH;
                end
                ST_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    next_state = ST_FETCH;
                end
            endcase
        end
    end

    assign mem.mem_req = req_c;
    assign alu_src_b   = srcb_c;
    assign trap_cause  = rst ? 2'b00 : cause_q;

`ifdef RV32I_CTRL_PERF_EN
    logic [31:0] cycle_q, retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (instr_retired) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign cycle_count   = rst ? 32'd0 : cycle_q;
    assign retired_count = rst ? 32'd0 : retired_q;
`endif

endmodule
